// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: valid/ready handshake, optional one-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module ex_mem_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned MOP_W   = 4,
   parameter int unsigned SKID_EN = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [MOP_W-1:0]  ex_mop,
   input  logic [DATA_W-1:0] ex_maddr,
   input  logic [DATA_W-1:0] ex_msdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MOP_W-1:0]  mem_mop,
   output logic [DATA_W-1:0] mem_maddr,
   output logic [DATA_W-1:0] mem_msdata,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned PW = ADDR_W + 1 + MOP_W + 3 * DATA_W;

   logic [PW-1:0]    in_pl;
   logic [PW-1:0]    main_q, main_d;
   logic [PW-1:0]    skid_q, skid_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             acc, pop;

   assign in_pl = {ex_wd, ex_wreg, ex_wdata, ex_mop, ex_maddr, ex_msdata};
   assign {mem_wd, mem_wreg, mem_wdata, mem_mop, mem_maddr, mem_msdata} = main_q;
   assign mem_valid = main_valid_q;
   assign stall_cnt = stall_q;

   // With the skid, ready comes straight from a flop so EX never sees mem_ready.
   assign ex_ready = (SKID_EN != 0) ? ~skid_valid_q : (~main_valid_q | mem_ready);

   assign acc = ex_valid & ex_ready;
   assign pop = main_valid_q & mem_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_d       = '0;
         main_valid_d = 1'b0;
         skid_d       = '0;
         skid_valid_d = 1'b0;
      end else if (SKID_EN == 0) begin
         // Skid flops stay at reset value here and are pruned in synthesis.
         if (acc) begin
            main_d       = in_pl;
            main_valid_d = 1'b1;
         end else if (pop) begin
            main_d       = '0;
            main_valid_d = 1'b0;
         end
      end else if (!main_valid_q) begin
         if (acc) begin
            main_d       = in_pl;
            main_valid_d = 1'b1;
         end
      end else if (!skid_valid_q) begin
         if (acc && mem_ready) begin
            main_d = in_pl;
         end else if (acc) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
         end else if (mem_ready) begin
            main_d       = '0;
            main_valid_d = 1'b0;
         end
      end else if (mem_ready) begin
         main_d       = skid_q;
         skid_d       = '0;
         skid_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (main_valid_q && !mem_ready && !(&stall_q)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         stall_q      <= stall_d;
      end
   end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: default, no-skid and 2-bit-counter instances share
// stimulus; a scoreboard queue tracks accepted entries against what MEM pops.
module tb_ex_mem_pipe;

   localparam int unsigned PW = 5 + 1 + 4 + 3 * 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush, ex_valid, mem_ready;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata, ex_maddr, ex_msdata;
   logic [3:0]  ex_mop;

   logic        ex_ready, mem_valid, mem_wreg;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata, mem_maddr, mem_msdata;
   logic [3:0]  mem_mop;
   logic [15:0] stall_cnt;

   logic        n_ready, n_valid, n_wreg;
   logic [4:0]  n_wd;
   logic [31:0] n_wdata, n_maddr, n_msdata;
   logic [3:0]  n_mop;
   logic [15:0] n_stall;

   logic        c_ready, c_valid, c_wreg;
   logic [4:0]  c_wd;
   logic [31:0] c_wdata, c_maddr, c_msdata;
   logic [3:0]  c_mop;
   logic [1:0]  c_stall;

   logic [PW-1:0] obs, n_obs;
   logic [PW-1:0] sbq[$];
   int            vec = 0;
   int            errs = 0;

   assign obs   = {mem_wd, mem_wreg, mem_wdata, mem_mop, mem_maddr, mem_msdata};
   assign n_obs = {n_wd, n_wreg, n_wdata, n_mop, n_maddr, n_msdata};

   always #5 clk = ~clk;

   ex_mem_pipe dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_mop(ex_mop),
      .ex_maddr(ex_maddr), .ex_msdata(ex_msdata), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_mop(mem_mop), .mem_maddr(mem_maddr), .mem_msdata(mem_msdata),
      .stall_cnt(stall_cnt)
   );

   ex_mem_pipe #(.SKID_EN(0)) dut_n (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(n_ready),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_mop(ex_mop),
      .ex_maddr(ex_maddr), .ex_msdata(ex_msdata), .mem_valid(n_valid),
      .mem_ready(mem_ready), .mem_wd(n_wd), .mem_wreg(n_wreg), .mem_wdata(n_wdata),
      .mem_mop(n_mop), .mem_maddr(n_maddr), .mem_msdata(n_msdata), .stall_cnt(n_stall)
   );

   ex_mem_pipe #(.CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(c_ready),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_mop(ex_mop),
      .ex_maddr(ex_maddr), .ex_msdata(ex_msdata), .mem_valid(c_valid),
      .mem_ready(mem_ready), .mem_wd(c_wd), .mem_wreg(c_wreg), .mem_wdata(c_wdata),
      .mem_mop(c_mop), .mem_maddr(c_maddr), .mem_msdata(c_msdata), .stall_cnt(c_stall)
   );

   // Payload tagged by wd: wdata 0x11 for wd=1, 0x22 for wd=2, ...
   function automatic logic [PW-1:0] pl(input logic [4:0] wd);
      logic [31:0] wdata;
      wdata = {24'h0, wd[3:0], wd[3:0]};
      return {wd, 1'b1, wdata, wd[3:0], 32'h1000_0000 + {27'h0, wd}, 32'hdead_0000 | {27'h0, wd}};
   endfunction

   task automatic set_in(input logic v, input logic [4:0] wd, input logic mr, input logic fl);
      ex_valid  = v;
      {ex_wd, ex_wreg, ex_wdata, ex_mop, ex_maddr, ex_msdata} = pl(wd);
      mem_ready = mr;
      flush     = fl;
   endtask

   task automatic do_reset;
      @(negedge clk);
      set_in(1'b0, 5'd0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
   endtask

   task automatic test_reset;
      @(negedge clk);
      #1;
      vec++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", mem_valid); end
      vec++; if (obs !== '0) begin errs++; $display("FAIL rst_payload got %h want 0", obs); end
      vec++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", ex_ready); end
      vec++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
      vec++; if (n_ready !== 1'b1) begin errs++; $display("FAIL rst_n_ready got %b want 1", n_ready); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         set_in(i < 4, 5'(i + 1), 1'b1, 1'b0);
         #1;
         vec++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready cyc %0d got %b want 1", i, ex_ready); end
         vec++; if (mem_valid !== (i >= 1 && i <= 4)) begin errs++; $display("FAIL b2b_valid cyc %0d got %b want %b", i, mem_valid, (i >= 1 && i <= 4)); end
         if (i < 4) sbq.push_back(pl(5'(i + 1)));
         if (mem_valid && mem_ready) begin
            vec++;
            if (sbq.size() == 0 || obs !== sbq[0]) begin errs++; $display("FAIL b2b_data cyc %0d got %h want %h", i, obs, (sbq.size() > 0) ? sbq[0] : '0); end
            if (sbq.size() > 0) void'(sbq.pop_front());
         end
      end
      vec++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL b2b_stall got %0d want 0", stall_cnt); end
      vec++; if (sbq.size() != 0) begin errs++; $display("FAIL b2b_left got %0d want 0", sbq.size()); end
   endtask

   task automatic test_skid;
      logic       ev_t [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [4:0] wd_t [8] = '{1, 2, 3, 3, 3, 3, 0, 0};
      logic       mr_t [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
      logic       rd_t [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
      logic       mv_t [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
      int         pops = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_in(ev_t[i], wd_t[i], mr_t[i], 1'b0);
         #1;
         vec++; if (ex_ready !== rd_t[i]) begin errs++; $display("FAIL skid_ready cyc %0d got %b want %b", i, ex_ready, rd_t[i]); end
         vec++; if (mem_valid !== mv_t[i]) begin errs++; $display("FAIL skid_valid cyc %0d got %b want %b", i, mem_valid, mv_t[i]); end
         if (ev_t[i] && rd_t[i]) sbq.push_back(pl(wd_t[i]));
         if (mem_valid && mem_ready) begin
            pops++;
            vec++;
            if (sbq.size() == 0 || obs !== sbq[0]) begin errs++; $display("FAIL skid_data cyc %0d got %h want %h", i, obs, (sbq.size() > 0) ? sbq[0] : '0); end
            if (sbq.size() > 0) void'(sbq.pop_front());
         end
      end
      vec++; if (pops != 3) begin errs++; $display("FAIL skid_pops got %0d want 3", pops); end
      vec++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL skid_stall got %0d want 3", stall_cnt); end
   endtask

   task automatic test_flush;
      do_reset();
      @(negedge clk); set_in(1'b1, 5'd1, 1'b0, 1'b0);
      @(negedge clk); set_in(1'b1, 5'd2, 1'b0, 1'b0);
      @(negedge clk); set_in(1'b1, 5'd3, 1'b0, 1'b1);
      #1;
      vec++; if (ex_ready !== 1'b0) begin errs++; $display("FAIL flush_full_ready got %b want 0", ex_ready); end
      // Flush discards an entry accepted in the same cycle too.
      @(negedge clk); set_in(1'b1, 5'd4, 1'b0, 1'b1);
      #1;
      vec++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", mem_valid); end
      vec++; if (obs !== '0) begin errs++; $display("FAIL flush_payload got %h want 0", obs); end
      vec++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL flush_ready got %b want 1", ex_ready); end
      @(negedge clk); set_in(1'b1, 5'd5, 1'b1, 1'b0);
      #1;
      vec++; if (mem_valid !== 1'b0 || obs !== '0) begin errs++; $display("FAIL flush_acc_drop got %b/%h want 0/0", mem_valid, obs); end
      vec++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL flush_stall got %0d want 2", stall_cnt); end
      @(negedge clk); set_in(1'b0, 5'd0, 1'b1, 1'b0);
      #1;
      vec++; if (mem_valid !== 1'b1 || obs !== pl(5'd5)) begin errs++; $display("FAIL flush_next got %b/%h want 1/%h", mem_valid, obs, pl(5'd5)); end
   endtask

   task automatic test_async_reset;
      do_reset();
      @(negedge clk); set_in(1'b1, 5'd1, 1'b0, 1'b0);
      @(negedge clk); set_in(1'b1, 5'd2, 1'b0, 1'b0);
      @(negedge clk); set_in(1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      vec++; if (mem_valid !== 1'b1 || ex_ready !== 1'b0) begin errs++; $display("FAIL arst_full got %b/%b want 1/0", mem_valid, ex_ready); end
      #2 rst = 1'b1;
      #1;
      vec++; if (mem_valid !== 1'b0 || obs !== '0) begin errs++; $display("FAIL arst_out got %b/%h want 0/0", mem_valid, obs); end
      vec++; if (ex_ready !== 1'b1 || stall_cnt !== 16'd0) begin errs++; $display("FAIL arst_ready got %b/%0d want 1/0", ex_ready, stall_cnt); end
      @(negedge clk);
      rst = 1'b0;
      set_in(1'b1, 5'd6, 1'b1, 1'b0);
      @(negedge clk); set_in(1'b0, 5'd0, 1'b1, 1'b0);
      #1;
      vec++; if (mem_valid !== 1'b1 || obs !== pl(5'd6)) begin errs++; $display("FAIL arst_after got %b/%h want 1/%h", mem_valid, obs, pl(5'd6)); end
   endtask

   task automatic test_noskid;
      do_reset();
      @(negedge clk); set_in(1'b1, 5'd1, 1'b0, 1'b0);
      #1;
      vec++; if (n_ready !== 1'b1) begin errs++; $display("FAIL nsk_empty_ready got %b want 1", n_ready); end
      @(negedge clk); set_in(1'b1, 5'd2, 1'b0, 1'b0);
      #1;
      vec++; if (n_ready !== 1'b0) begin errs++; $display("FAIL nsk_stall_ready got %b want 0", n_ready); end
      vec++; if (n_valid !== 1'b1 || n_obs !== pl(5'd1)) begin errs++; $display("FAIL nsk_main got %b/%h want 1/%h", n_valid, n_obs, pl(5'd1)); end
      mem_ready = 1'b1;
      #1;
      vec++; if (n_ready !== 1'b1) begin errs++; $display("FAIL nsk_comb_ready got %b want 1", n_ready); end
      @(negedge clk); set_in(1'b0, 5'd0, 1'b1, 1'b0);
      #1;
      vec++; if (n_valid !== 1'b1 || n_obs !== pl(5'd2)) begin errs++; $display("FAIL nsk_replace got %b/%h want 1/%h", n_valid, n_obs, pl(5'd2)); end
      @(negedge clk);
      #1;
      vec++; if (n_valid !== 1'b0 || n_obs !== '0) begin errs++; $display("FAIL nsk_drain got %b/%h want 0/0", n_valid, n_obs); end
   endtask

   task automatic test_stall_sat;
      logic [1:0] exp_t [6] = '{1, 2, 3, 3, 3, 3};
      do_reset();
      @(negedge clk); set_in(1'b1, 5'd1, 1'b1, 1'b0);
      @(negedge clk); set_in(1'b0, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         vec++; if (c_stall !== exp_t[k]) begin errs++; $display("FAIL sat_cnt step %0d got %0d want %0d", k, c_stall, exp_t[k]); end
      end
      vec++; if (c_valid !== 1'b1) begin errs++; $display("FAIL sat_valid got %b want 1", c_valid); end
   endtask

   initial begin
      set_in(1'b0, 5'd0, 1'b0, 1'b0);
      test_reset();
      test_back_to_back();
      test_skid();
      test_flush();
      test_async_reset();
      test_noskid();
      test_stall_sat();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX->MEM pipeline register with a valid/ready handshake, an optional one-entry skid buffer, synchronous flush and a saturating back-pressure counter.
- Carries the write-back triple (wd, wreg, wdata) plus the load/store fields: op, address and store data.
- Sits between the execute stage and the memory-access stage.
- Lets the LSU stall MEM without a combinational ready path back into EX.

Parameters:
- DATA_W, 32, width of wdata, memory address and store data.
- ADDR_W, 5, register-file address width.
- MOP_W, 4, memory-op code width; code 0 = no memory access.
- SKID_EN, 1, 1 = two-entry skid buffer with registered ex_ready; 0 = single entry with combinational ex_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming entries.
- ex_valid  in  1  EX presents a valid entry.
- ex_ready  out  1  block can accept this cycle.
- ex_wd  in  ADDR_W  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  DATA_W  ALU result.
- ex_mop  in  MOP_W  memory op code.
- ex_maddr  in  DATA_W  memory address.
- ex_msdata  in  DATA_W  store data.
- mem_valid  out  1  MEM-side entry valid.
- mem_ready  in  1  MEM consumes the entry this cycle.
- mem_wd, mem_wreg, mem_wdata, mem_mop, mem_maddr, mem_msdata  out  as the ex_ inputs  registered payload.
- stall_cnt  out  CNT_W  saturating count of cycles with mem_valid=1 and mem_ready=0.

Behaviour:
- Definitions: acc = ex_valid & ex_ready; pop = mem_valid & mem_ready.
- Storage: main entry (drives all mem_ outputs directly from flops) and skid entry (present only if SKID_EN=1).
- Reset (async): main_valid=0, skid_valid=0, stall_cnt=0, every payload output 0. This gives wd=0, wreg=WriteDisable, data=ZeroWord, mop=0.
- Reset state of ex_ready: 1 during and after reset.
- NOP rule: whenever main becomes or stays invalid, main payload is loaded with all-zero values. mem_wreg=1 therefore never appears with mem_valid=0.
- SKID_EN=1: ex_ready = ~skid_valid, a registered flop output. States:
  - EMPTY (main 0, skid 0): acc -> BUSY, main<=in.
  - BUSY (main 1, skid 0):
    - acc & mem_ready -> BUSY, main<=in.
    - acc & ~mem_ready -> FULL, skid<=in.
    - ~acc & mem_ready -> EMPTY, main<=NOP.
    - otherwise hold.
  - FULL (main 1, skid 1): mem_ready -> BUSY, main<=skid, skid<=NOP; otherwise hold. No acc is possible because ex_ready=0.
- SKID_EN=0:
  - ex_ready = ~main_valid | mem_ready (combinational).
  - main<=in on acc.
  - main<=NOP on pop without acc.
  - Skid logic is absent.
- Latency: an accepted entry appears on the mem_ outputs the cycle after acceptance in BUSY/EMPTY. In FULL it is delayed by the skid.
- Throughput: 1 entry/cycle while mem_ready=1.
- Ordering is strict FIFO; the skid is never bypassed by a newer entry.
- Flush (highest priority below reset): next edge sets main and skid to invalid + NOP.
  - An input accepted in the same cycle is discarded.
  - ex_ready is 1 the cycle after the flush.
  - A pop coinciding with flush still counts as consumed by MEM.
- stall_cnt:
  - Increments when mem_valid & ~mem_ready.
  - Saturates at 2^CNT_W-1, no wrap.
  - Not cleared by flush; cleared only by rst.
- Reset asserted mid-transfer: outputs drop to reset values immediately, without waiting for clk. All held entries are lost.

Test Plan:
- Reset then 4 back-to-back entries, wd=1..4, wdata=0x11..0x44, mem_ready=1 -> mem_wd sequence 1,2,3,4 on consecutive cycles; mem_valid high 4 cycles; ex_ready constantly 1; stall_cnt=0.
- Entry A accepted, then mem_ready=0 while B is offered -> B goes to skid; ex_ready=0 next cycle. C is held by EX. Raise mem_ready -> outputs A, B, C in order with no loss or duplication; stall_cnt equals stalled cycles.
- FULL state, then flush=1 with ex_valid=1 -> next cycle mem_valid=0, mem_wreg=0, all payload 0, ex_ready=1. The flushed input never appears.
- Assert rst asynchronously mid-cycle while FULL -> outputs zero before the next clk edge; ex_ready=1. Deassert, send 1 entry -> it appears normally.
- SKID_EN=0, mem_ready=0 with main valid -> ex_ready=0 combinationally. Toggling mem_ready=1 in the same cycle raises ex_ready and accepts; new entry replaces the popped one.
- CNT_W=2, hold mem_ready=0 for 6 cycles with main valid -> stall_cnt reads 1,2,3,3,3,3.
